// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential add/subtract ALU.
// Provides state encoding, datapath width and slice-count helper.
package alu_pkg;

   localparam int ALU_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } alu_seq_state_t;

   function automatic int alu_slices(input int slice_w);
      return ALU_W / slice_w;
   endfunction

endpackage

// File: rtl/alu_addsub_seq_32_bit_if.sv
// Request/result bundle for alu_addsub_seq_32_bit.
// master: start, sub, X, Y (ci with ADDSUB_CI_EN) out; busy, done, sum, co, ovf, zero in.
interface alu_addsub_seq_32_bit_if;
   import alu_pkg::*;

   logic             start;
   logic             sub;
   logic [ALU_W-1:0] X;
   logic [ALU_W-1:0] Y;
`ifdef ADDSUB_CI_EN
   logic             ci;
`endif
   logic             busy;
   logic             done;
   logic [ALU_W-1:0] sum;
   logic             co;
   logic             ovf;
   logic             zero;

   modport master (
`ifdef ADDSUB_CI_EN
      output ci,
`endif
      output start, sub, X, Y,
      input  busy, done, sum, co, ovf, zero
   );

   modport slave (
`ifdef ADDSUB_CI_EN
      input  ci,
`endif
      input  start, sub, X, Y,
      output busy, done, sum, co, ovf, zero
   );

endinterface

// File: rtl/add_rca_slice.sv
// Combinational W-bit ripple-carry slice.
// Ports: a, b, cin in; s, cout, c_msb_in (carry into the top bit) out.
module add_rca_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb_in
);

   logic [W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[W];
   assign c_msb_in = c[W-1];

endmodule

// File: rtl/alu_addsub_seq_32_bit.sv
// Multi-cycle 32-bit add/subtract, SLICE_W bits per cycle via one reused RCA slice.
// Ports: clk, rst (async, active high), bus (slave modport). Macro ADDSUB_CI_EN adds ci.
module alu_addsub_seq_32_bit
   import alu_pkg::*;
#(
   parameter int SLICE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_addsub_seq_32_bit_if.slave bus
);

   localparam int N      = alu_slices(SLICE_W);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int BASE_W = $clog2(ALU_W);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   alu_seq_state_t   state_q, state_d;
   logic [ALU_W-1:0] a_q, a_d;
   logic [ALU_W-1:0] b_q, b_d;
   logic [ALU_W-1:0] sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             c31_q, c31_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [BASE_W-1:0]  base;
   logic [SLICE_W-1:0] sl_a;
   logic [SLICE_W-1:0] sl_b;
   logic [SLICE_W-1:0] sl_s;
   logic               sl_cout;
   logic               sl_c31;
   logic               cin0;

   assign base = BASE_W'(int'(idx_q) * SLICE_W);
   assign sl_a = a_q[base +: SLICE_W];
   assign sl_b = b_q[base +: SLICE_W];

`ifdef ADDSUB_CI_EN
   assign cin0 = bus.ci;
`else
   assign cin0 = bus.sub;
`endif

   add_rca_slice #(
      .W (SLICE_W)
   ) u_slice (
      .a        (sl_a),
      .b        (sl_b),
      .cin      (carry_q),
      .s        (sl_s),
      .cout     (sl_cout),
      .c_msb_in (sl_c31)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      c31_d   = c31_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.X;
               b_d     = bus.sub ? ~bus.Y : bus.Y;
               carry_d = cin0;
               idx_d   = '0;
               sum_d   = '0;
               co_d    = 1'b0;
               ovf_d   = 1'b0;
               zero_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[base +: SLICE_W] = sl_s;
            carry_d = sl_cout;
            // only the value from the last slice survives
            c31_d   = sl_c31;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            co_d    = carry_q;
            ovf_d   = c31_q ^ carry_q;
            zero_d  = (sum_q == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c31_q   <= 1'b0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         c31_q   <= c31_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.co   = co_q;
   assign bus.ovf  = ovf_q;
   assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu_addsub_seq_32_bit.sv
// Bench for alu_addsub_seq_32_bit: four instances (SLICE_W 4, 1, 8, 32) share stimulus.
// Table vectors, hand sequences (ignored start, back-to-back, reset abort), random vs model.
module tb_alu_addsub_seq_32_bit;

   localparam int ND = 4;
`ifdef ADDSUB_CI_EN
   localparam int NCI = 2;
`else
   localparam int NCI = 1;
`endif
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   typedef struct packed {
      logic [32:0] cs;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        sub;
      logic        ci;
      logic [32:0] cs;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sub;
   logic        ci;
   logic [31:0] x;
   logic [31:0] y;

   logic [ND-1:0] done_v, busy_v, co_v, ovf_v, zero_v;
   logic [31:0]   sum_v [ND];

   int          cyc = 0;
   int          done_cnt [ND];
   int          done_cyc [ND];
   logic [32:0] res_cs   [ND];
   logic        res_ovf  [ND];
   logic        res_zero [ND];
   int          zero_busy [ND];
   int          nvec = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int W = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
      alu_addsub_seq_32_bit_if bus ();
      assign bus.start = start;
      assign bus.sub   = sub;
      assign bus.X     = x;
      assign bus.Y     = y;
`ifdef ADDSUB_CI_EN
      assign bus.ci    = ci;
`endif
      assign done_v[g] = bus.done;
      assign busy_v[g] = bus.busy;
      assign co_v[g]   = bus.co;
      assign ovf_v[g]  = bus.ovf;
      assign zero_v[g] = bus.zero;
      assign sum_v[g]  = bus.sum;
      alu_addsub_seq_32_bit #(
         .SLICE_W (W)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < ND; k++) begin
         if (done_v[k]) begin
            done_cnt[k] = done_cnt[k] + 1;
            done_cyc[k] = cyc;
            res_cs[k]   = {co_v[k], sum_v[k]};
            res_ovf[k]  = ovf_v[k];
            res_zero[k] = zero_v[k];
         end
         if (busy_v[k] && zero_v[k]) zero_busy[k] = zero_busy[k] + 1;
      end
   end

   function automatic int sw_of(input int k);
      case (k)
         0: return 4;
         1: return 1;
         2: return 8;
         default: return 32;
      endcase
   endfunction

   function automatic res_t ref_model(input logic [31:0] xa, input logic [31:0] ya,
                                      input logic sa, input logic ca);
      res_t        r;
      logic [31:0] yy;
      logic        cin;
      longint      sr;
      yy = sa ? ~ya : ya;
`ifdef ADDSUB_CI_EN
      cin = ca;
`else
      cin = sa;
      if (ca) cin = sa;
`endif
      r.cs   = {1'b0, xa} + {1'b0, yy} + 33'(cin);
      sr     = longint'($signed(xa)) + longint'($signed(yy)) + longint'(cin);
      r.ovf  = (sr > MAXS) || (sr < MINS);
      r.zero = (r.cs[31:0] == 32'h0);
      return r;
   endfunction

   task automatic chk(input string nm, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s sw%0d: got %0h want %0h", nm, sw_of(k), act, exp);
      end
   endtask

   task automatic clear_mon();
      for (int k = 0; k < ND; k++) done_cnt[k] = 0;
   endtask

   function automatic bit all_done();
      for (int k = 0; k < ND; k++) if (done_cnt[k] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic idle_wait(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [31:0] xa, input logic [31:0] ya,
                        input logic sa, input logic ca, output int s);
      @(negedge clk);
      #1;
      x = xa;
      y = ya;
      sub = sa;
      ci = ca;
      start = 1'b1;
      s = cyc;
      @(negedge clk);
      #1;
      start = 1'b0;
      x = $urandom;
      y = $urandom;
      sub = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
   endtask

   task automatic do_op(input logic [31:0] xa, input logic [31:0] ya,
                        input logic sa, input logic ca, input res_t e,
                        input string nm);
      int s;
      int budget;
      clear_mon();
      issue(xa, ya, sa, ca, s);
      budget = 0;
      while (!all_done() && budget < 60) begin
         idle_wait(1);
         budget++;
      end
      idle_wait(2);
      for (int k = 0; k < ND; k++) begin
         chk({nm, "_pulses"}, k, 64'(done_cnt[k]), 64'd1);
         chk({nm, "_latency"}, k, 64'(done_cyc[k] - s - 1), 64'(32 / sw_of(k) + 1));
         chk({nm, "_cosum"}, k, 64'(res_cs[k]), 64'(e.cs));
         chk({nm, "_ovf"}, k, 64'(res_ovf[k]), 64'(e.ovf));
         chk({nm, "_zero"}, k, 64'(res_zero[k]), 64'(e.zero));
         chk({nm, "_held"}, k, 64'({co_v[k], sum_v[k]}), 64'(e.cs));
      end
   endtask

   vec_t tbl [6];

   initial begin
      res_t e;
      res_t eb;
      int   s1;
      int   s2;
      int   budget;
      logic [31:0] xr;
      logic [31:0] yr;

      tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 33'h0_0000_0008, 1'b0, 1'b0};
      tbl[1] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 1'b0, 1'b0};
      tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h0_8000_0000, 1'b1, 1'b0};
      tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33'h1_0000_0000, 1'b0, 1'b1};
      tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 33'h1_7FFF_FFFF, 1'b1, 1'b0};
      tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 33'h1_0000_0000, 1'b0, 1'b1};

      for (int k = 0; k < ND; k++) begin
         done_cnt[k] = 0;
         done_cyc[k] = 0;
         zero_busy[k] = 0;
         res_cs[k] = '0;
         res_ovf[k] = 1'b0;
         res_zero[k] = 1'b0;
      end
      rst = 1'b1;
      start = 1'b0;
      sub = 1'b0;
      ci = 1'b0;
      x = '0;
      y = '0;
      idle_wait(3);
      for (int k = 0; k < ND; k++)
         chk("reset_outputs", k,
             64'({busy_v[k], done_v[k], co_v[k], ovf_v[k], zero_v[k], sum_v[k]}), 64'd0);
      rst = 1'b0;
      idle_wait(2);

      for (int i = 0; i < 6; i++)
         do_op(tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].ci,
               '{tbl[i].cs, tbl[i].ovf, tbl[i].zero}, $sformatf("table%0d", i));

      // start during RUN is ignored; the N=1 instance is idle again and takes it
      e  = ref_model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      eb = ref_model(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b1);
      clear_mon();
      issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s1);
      idle_wait(2);
      x = 32'hFFFF_0000;
      y = 32'h0000_FFFF;
      sub = 1'b1;
      ci = 1'b1;
      start = 1'b1;
      idle_wait(1);
      start = 1'b0;
      idle_wait(45);
      for (int k = 0; k < 3; k++) begin
         chk("ignored_pulses", k, 64'(done_cnt[k]), 64'd1);
         chk("ignored_result", k, 64'(res_cs[k]), 64'(e.cs));
      end
      chk("idle_accept_pulses", 3, 64'(done_cnt[3]), 64'd2);
      chk("idle_accept_result", 3, 64'(res_cs[3]), 64'(eb.cs));

      // back-to-back: start in the cycle after done, SLICE_W=4 instance
      e  = ref_model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
      eb = ref_model(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1);
      clear_mon();
      issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0, s1);
      budget = 0;
      while (done_cnt[0] == 0 && budget < 40) begin
         idle_wait(1);
         budget++;
      end
      chk("b2b_first", 0, 64'(res_cs[0]), 64'(e.cs));
      x = 32'h0000_0010;
      y = 32'h0000_0020;
      sub = 1'b1;
      ci = 1'b1;
      start = 1'b1;
      s2 = cyc;
      idle_wait(1);
      start = 1'b0;
      idle_wait(45);
      chk("b2b_pulses", 0, 64'(done_cnt[0]), 64'd2);
      chk("b2b_latency", 0, 64'(done_cyc[0] - s2 - 1), 64'd9);
      chk("b2b_second", 0, 64'(res_cs[0]), 64'(eb.cs));

      // reset four cycles into RUN aborts everything
      clear_mon();
      issue(32'hAAAA_5555, 32'h1234_0001, 1'b0, 1'b0, s1);
      idle_wait(4);
      rst = 1'b1;
      #1;
      for (int k = 0; k < ND; k++)
         chk("abort_outputs", k,
             64'({busy_v[k], done_v[k], co_v[k], ovf_v[k], zero_v[k], sum_v[k]}), 64'd0);
      clear_mon();
      idle_wait(1);
      rst = 1'b0;
      idle_wait(45);
      for (int k = 0; k < ND; k++)
         chk("abort_no_done", k, 64'(done_cnt[k]), 64'd0);
      do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0,
            ref_model(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0), "after_reset");

      for (int i = 0; i < 512; i++) begin
         xr = $urandom;
         yr = $urandom;
         for (int sb = 0; sb < 2; sb++) begin
            for (int c = 0; c < NCI; c++) begin
               e = ref_model(xr, yr, 1'(sb), 1'(c));
               do_op(xr, yr, 1'(sb), 1'(c), e, "random");
            end
         end
      end

      for (int k = 0; k < ND; k++)
         chk("zero_while_busy", k, 64'(zero_busy[k]), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
